// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the dual-core memory arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic [MEM_DATA_W-1:0] SC_SUCCESS = 32'd1;
    localparam logic [MEM_DATA_W-1:0] SC_FAIL    = 32'd0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    typedef enum logic [2:0] {
        REQ_IFETCH,
        REQ_LOAD,
        REQ_STORE,
        REQ_LL,
        REQ_SC
    } req_type_t;

    // One reservation per core, tracked at word granularity.
    typedef struct packed {
        logic                  valid;
        logic [MEM_ADDR_W-3:0] word_addr;
    } link_t;

    // Request kinds that end in a RAM write strobe (an SC only if its check passed).
    function automatic logic is_write(input req_type_t t);
        return (t == REQ_STORE) || (t == REQ_SC);
    endfunction

endpackage

// File: rtl/llsc_link_unit.sv
// LL/SC reservation registers for both cores: answers the SC check for the
// request being granted and applies set/clear rules when a transaction retires.
module llsc_link_unit
    import mem_arb_pkg::*;
#(
    parameter int WORD_W = MEM_ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q_core,
    input  logic [WORD_W-1:0] q_word,
    output logic              sc_pass,
    input  logic              done,
    input  logic              d_core,
    input  req_type_t         d_type,
    input  logic [WORD_W-1:0] d_word,
    input  logic              d_wrote
);

    link_t links [2];

    assign sc_pass = links[q_core].valid && (links[q_core].word_addr == q_word);

    for (genvar k = 0; k < 2; k++) begin : g_link
        // Update one core's reservation when a transaction retires.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
            if (rst) begin
                // NOTE: only the valid bit is reset; the word address is don't-care while invalid.
                links[k].valid <= 1'b0;
            end else if (done) begin
                if (d_core == 1'(k)) begin
                    if (d_type == REQ_LL) begin
                        links[k].valid     <= 1'b1;
                        links[k].word_addr <= d_word;
                    end else if (d_type == REQ_SC) begin
                        links[k].valid <= 1'b0;
                    end
                end else if (d_wrote && (links[k].word_addr == d_word)) begin
                    // A write by the other core breaks this core's reservation.
                    links[k].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Serializes instruction and data requests of two cores onto one RAM port.
// Round-robin between cores, data before fetch within a core; failed SCs
// are answered without touching RAM.
module dual_core_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int NCORE  = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NCORE-1:0]              iREN,
    input  logic [NCORE-1:0][ADDR_W-1:0]  iaddr,
    input  logic [NCORE-1:0]              dREN,
    input  logic [NCORE-1:0]              dWEN,
    input  logic [NCORE-1:0]              llsc,
    input  logic [NCORE-1:0][ADDR_W-1:0]  daddr,
    input  logic [NCORE-1:0][DATA_W-1:0]  dstore,
    output logic [NCORE-1:0]              iwait,
    output logic [NCORE-1:0]              dwait,
    output logic [NCORE-1:0][DATA_W-1:0]  iload,
    output logic [NCORE-1:0][DATA_W-1:0]  dload,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [ADDR_W-1:0]             ramaddr,
    output logic [DATA_W-1:0]             ramstore,
    input  logic [DATA_W-1:0]             ramload,
    input  logic                          ramready
);

    arb_state_t state_q, state_d;
    logic       rr_q;

    // Registered grant
    logic              g_core_q;
    req_type_t         g_type_q;
    logic [ADDR_W-1:0] g_addr_q;
    logic [DATA_W-1:0] g_data_q;
    logic              g_sc_pass_q;

    logic [NCORE-1:0][DATA_W-1:0] iload_q, dload_q;

    // Arbitration result for the current IDLE cycle
    logic              pick_valid, pick_core, pick_is_d;
    req_type_t         pick_type;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;
    logic              sc_pass;
    logic [NCORE-1:0]  dreq;

    assign dreq  = dREN | dWEN;
    assign iload = iload_q;
    assign dload = dload_q;

    // Pick the winner: d[rr], i[rr], d[~rr], i[~rr].
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pick_valid = 1'b1;
        pick_core  = rr_q;
        pick_is_d  = 1'b1;
        if (dreq[rr_q]) begin
            pick_core = rr_q;
        end else if (iREN[rr_q]) begin
            pick_is_d = 1'b0;
        end else if (dreq[~rr_q]) begin
            pick_core = ~rr_q;
        end else if (iREN[~rr_q]) begin
            pick_core = ~rr_q;
            pick_is_d = 1'b0;
        end else begin
            pick_valid = 1'b0;
        end

        if (!pick_is_d)           pick_type = REQ_IFETCH;
        else if (dWEN[pick_core]) pick_type = llsc[pick_core] ? REQ_SC : REQ_STORE;
        else                      pick_type = llsc[pick_core] ? REQ_LL : REQ_LOAD;

        pick_addr = pick_is_d ? daddr[pick_core] : iaddr[pick_core];
        pick_data = pick_is_d ? dstore[pick_core] : '0;
    end

    llsc_link_unit #(
        .WORD_W (ADDR_W - 2)
    ) u_link (
        .clk     (CLK),
        .rst     (RST),
        .q_core  (pick_core),
        .q_word  (pick_addr[ADDR_W-1:2]),
        .sc_pass (sc_pass),
        .done    (state_q == DONE),
        .d_core  (g_core_q),
        .d_type  (g_type_q),
        .d_word  (g_addr_q[ADDR_W-1:2]),
        .d_wrote ((g_type_q == REQ_STORE) || ((g_type_q == REQ_SC) && g_sc_pass_q))
    );

    // Next state and port outputs from the current state and registered grant.
    always_comb begin
        state_d  = state_q;
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) state_d = ((pick_type == REQ_SC) && !sc_pass) ? DONE : ACCESS;
            end
            ACCESS: begin
                ramREN   = !is_write(g_type_q);
                ramWEN   = is_write(g_type_q);
                ramaddr  = g_addr_q;
                ramstore = g_data_q;
                if (ramready) state_d = DONE;
            end
            DONE: begin
                if (g_type_q == REQ_IFETCH) iwait[g_core_q] = 1'b0;
                else                        dwait[g_core_q] = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DONE) rr_q <= ~g_core_q;
        end
    end

    // Grant capture and per-core result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            g_core_q    <= 1'b0;
            g_type_q    <= REQ_IFETCH;
            g_addr_q    <= '0;
            g_data_q    <= '0;
            g_sc_pass_q <= 1'b0;
            iload_q     <= '0;
            dload_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        g_core_q    <= pick_core;
                        g_type_q    <= pick_type;
                        g_addr_q    <= pick_addr;
                        g_data_q    <= pick_data;
                        g_sc_pass_q <= sc_pass;
                        if ((pick_type == REQ_SC) && !sc_pass) dload_q[pick_core] <= DATA_W'(SC_FAIL);
                    end
                end
                ACCESS: begin
                    if (ramready) begin
                        if (g_type_q == REQ_IFETCH)  iload_q[g_core_q] <= ramload;
                        else if (g_type_q == REQ_SC) dload_q[g_core_q] <= DATA_W'(SC_SUCCESS);
                        else if (!is_write(g_type_q)) dload_q[g_core_q] <= ramload;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Bench for dual_core_mem_arbiter: a transaction-level model of the arbiter
// (arbitration order, link table, memory image) checked every cycle, plus
// directed scenarios with literal expectations.
module tb_dual_core_mem_arbiter;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [1:0]       iREN, dREN, dWEN, llsc;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait;
    logic [1:0][31:0] iload, dload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore;
    logic [31:0]      ramload  = '0;
    logic             ramready = 1'b0;

    dual_core_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .llsc(llsc), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM environment ----------------
    logic [31:0] ram  [1024];   // contents the RAM holds
    logic [31:0] mmem [1024];   // contents the model believes memory holds
    int ram_lat  = 0;           // extra ACCESS cycles before ramready
    bit ram_spur = 1'b0;        // hold ramready high outside accesses
    int acc_cnt  = 0;
    int cyc      = 0;

    always @(negedge CLK) begin
        cyc++;
        if (ramREN || ramWEN) begin
            ramready = (acc_cnt >= ram_lat);
            ramload  = ram[ramaddr[11:2]];
            if (ramready && ramWEN) ram[ramaddr[11:2]] = ramstore;
            acc_cnt++;
        end else begin
            acc_cnt  = 0;
            ramready = ram_spur;
            ramload  = 32'hBAD0_0000 ^ 32'(cyc);
        end
    end

    // ---------------- Transaction model ----------------
    // m_stage: 0 = nothing granted, 1 = waiting on RAM, 2 = answering requester
    int          m_stage = 0;
    int          m_fav   = 0;
    int          m_core  = 0;
    bit          m_is_d, m_wr, m_ll, m_sc;
    logic [31:0] m_addr, m_data, m_result;
    bit          lk_v [2] = '{1'b0, 1'b0};
    logic [29:0] lk_w [2];

    task automatic model_grant();
        bit found = 1'b0;
        for (int o = 0; o < 4; o++) begin
            int c   = (o < 2) ? m_fav : 1 - m_fav;
            bit dat = (o % 2 == 0);
            bit req = dat ? (dREN[c] | dWEN[c]) : iREN[c];
            if (req && !found) begin
                found  = 1'b1;
                m_core = c;
                m_is_d = dat;
                m_wr   = dat && dWEN[c];
                m_sc   = dat && dWEN[c] && llsc[c];
                m_ll   = dat && dREN[c] && llsc[c];
                m_addr = dat ? daddr[c] : iaddr[c];
                m_data = dstore[c];
                if (m_sc && !(lk_v[c] && lk_w[c] == m_addr[31:2])) begin
                    m_wr     = 1'b0;
                    m_result = 32'd0;
                    m_stage  = 2;
                end else begin
                    m_stage = 1;
                end
            end
        end
    endtask

    task automatic model_retire();
        if (m_ll) begin
            lk_v[m_core] = 1'b1;
            lk_w[m_core] = m_addr[31:2];
        end
        if (m_sc) lk_v[m_core] = 1'b0;
        if (m_wr && lk_w[1-m_core] == m_addr[31:2]) lk_v[1-m_core] = 1'b0;
        m_fav   = 1 - m_core;
        m_stage = 0;
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            m_stage = 0;
            m_fav   = 0;
            lk_v    = '{1'b0, 1'b0};
        end else if (m_stage == 0) begin
            model_grant();
        end else if (m_stage == 1) begin
            if (ramready) begin
                if (m_wr) mmem[m_addr[11:2]] = m_data;
                else      m_result = mmem[m_addr[11:2]];
                if (m_sc) m_result = 32'd1;
                m_stage = 2;
            end
        end else begin
            model_retire();
        end
    end

    // ---------------- Per-cycle compare ----------------
    logic [3:0] e_w;
    always @(negedge CLK) begin
        e_w = 4'hF;   // {iwait[1], iwait[0], dwait[1], dwait[0]}
        if (m_stage == 2) begin
            if (m_is_d) e_w[m_core]     = 1'b0;
            else        e_w[2 + m_core] = 1'b0;
        end
        check("ram_en",   {ramREN, ramWEN}, {(m_stage == 1) && !m_wr, (m_stage == 1) && m_wr});
        check("ram_addr", ramaddr, (m_stage == 1) ? m_addr : 32'd0);
        check("waits",    {iwait, dwait}, e_w);
        if (m_stage == 1 && m_wr) check("ram_store", ramstore, m_data);
        if (m_stage == 2 && !m_is_d) check("iload", iload[m_core], m_result);
        if (m_stage == 2 && m_is_d && (m_sc || !m_wr)) check("dload", dload[m_core], m_result);
    end

    // ---------------- Directed stimulus ----------------
    task automatic clear_reqs();
        iREN = '0; dREN = '0; dWEN = '0; llsc = '0;
    endtask

    // Issue one request and hold it until its wait drops (bounded).
    task automatic issue(input int c, input bit is_d, input bit wr, input bit ls,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] val, output logic [3:0] w_done,
                         output bit saw_wen, output logic [31:0] wen_addr, output logic [31:0] wen_data);
        bit fin = 1'b0;
        lat = 0; val = '0; w_done = '0; saw_wen = 1'b0; wen_addr = '0; wen_data = '0;
        @(negedge CLK);
        if (is_d) begin
            dREN[c] = !wr; dWEN[c] = wr; llsc[c] = ls; daddr[c] = a; dstore[c] = d;
        end else begin
            iREN[c] = 1'b1; iaddr[c] = a;
        end
        for (int n = 0; n < 40 && !fin; n++) begin
            @(negedge CLK);
            if (ramWEN) begin
                saw_wen = 1'b1; wen_addr = ramaddr; wen_data = ramstore;
            end
            if (is_d ? !dwait[c] : !iwait[c]) begin
                fin    = 1'b1;
                lat    = n + 2;
                val    = is_d ? dload[c] : iload[c];
                w_done = {iwait, dwait};
            end
        end
        clear_reqs();
        if (!fin) check("timeout", 64'd0, 64'd1);
    endtask

    int          lat;
    logic [31:0] val, wa, wd;
    logic [3:0]  wdn;
    bit          sw;
    int          ord [3] = '{7, 7, 7};
    int          got = 0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = 32'h1000_0000 + 32'(i);
            mmem[i] = 32'h1000_0000 + 32'(i);
        end
        ram[16]  = 32'hDEAD_BEEF;
        mmem[16] = 32'hDEAD_BEEF;
        clear_reqs();
        iaddr = '0; daddr = '0; dstore = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset state
        check("rst_waits", {iwait, dwait}, 4'hF);
        check("rst_ram_en", {ramREN, ramWEN}, 2'b00);
        check("rst_ram_addr", ramaddr, 32'd0);
        check("rst_dload", dload, 64'd0);

        // d0, i0 and d1 all pending from reset: expect d0, d1, i0
        dREN[0] = 1'b1; daddr[0] = 32'h10;
        iREN[0] = 1'b1; iaddr[0] = 32'h14;
        dREN[1] = 1'b1; daddr[1] = 32'h18;
        RST = 1'b0;
        for (int n = 0; n < 60 && got < 3; n++) begin
            @(negedge CLK);
            if (!dwait[0])      begin ord[got] = 0; got++; dREN[0] = 1'b0; end
            else if (!dwait[1]) begin ord[got] = 1; got++; dREN[1] = 1'b0; end
            else if (!iwait[0]) begin ord[got] = 2; got++; iREN[0] = 1'b0; end
        end
        clear_reqs();
        check("order_0", ord[0], 0);
        check("order_1", ord[1], 1);
        check("order_2", ord[2], 2);

        // Fetch with immediate ramready
        issue(0, 0, 0, 0, 32'h40, 0, lat, val, wdn, sw, wa, wd);
        check("fetch_lat", lat, 3);
        check("fetch_data", val, 32'hDEAD_BEEF);
        check("fetch_waits", wdn, 4'b1011);

        // LL then SC to the same word succeeds and writes RAM
        issue(0, 1, 0, 1, 32'h100, 0, lat, val, wdn, sw, wa, wd);
        check("ll_data", val, 32'h1000_0040);
        issue(0, 1, 1, 1, 32'h100, 32'h5, lat, val, wdn, sw, wa, wd);
        check("sc_ok_val", val, 32'd1);
        check("sc_ok_lat", lat, 3);
        check("sc_ok_wen", {31'd0, sw}, 32'd1);
        check("sc_ok_addr", wa, 32'h100);
        check("sc_ok_store", wd, 32'h5);
        // The SC consumed the link: a second SC fails
        issue(0, 1, 1, 1, 32'h100, 32'h6, lat, val, wdn, sw, wa, wd);
        check("sc_again_val", val, 32'd0);
        check("sc_again_lat", lat, 2);

        // Other core's store to the linked word breaks the link
        issue(0, 1, 0, 1, 32'h100, 0, lat, val, wdn, sw, wa, wd);
        check("ll_reload", val, 32'h5);
        issue(1, 1, 1, 0, 32'h100, 32'h77, lat, val, wdn, sw, wa, wd);
        issue(0, 1, 1, 1, 32'h100, 32'h8, lat, val, wdn, sw, wa, wd);
        check("sc_broken_val", val, 32'd0);
        check("sc_broken_lat", lat, 2);
        check("sc_broken_wen", {31'd0, sw}, 32'd0);

        // Other core's store elsewhere leaves the link intact
        issue(0, 1, 0, 1, 32'h104, 0, lat, val, wdn, sw, wa, wd);
        issue(1, 1, 1, 0, 32'h200, 32'h55, lat, val, wdn, sw, wa, wd);
        issue(0, 1, 1, 1, 32'h104, 32'h9, lat, val, wdn, sw, wa, wd);
        check("sc_kept_val", val, 32'd1);

        // Own-core store does not clear own link
        issue(0, 1, 0, 1, 32'h300, 0, lat, val, wdn, sw, wa, wd);
        issue(0, 1, 1, 0, 32'h300, 32'h33, lat, val, wdn, sw, wa, wd);
        issue(0, 1, 1, 1, 32'h300, 32'h34, lat, val, wdn, sw, wa, wd);
        check("sc_own_sw_val", val, 32'd1);

        // A second LL moves the link
        issue(1, 1, 0, 1, 32'h400, 0, lat, val, wdn, sw, wa, wd);
        issue(1, 1, 0, 1, 32'h500, 0, lat, val, wdn, sw, wa, wd);
        issue(1, 1, 1, 1, 32'h400, 32'h44, lat, val, wdn, sw, wa, wd);
        check("sc_moved_val", val, 32'd0);
        check("sc_moved_dload1", dload[1], 32'd0);

        // Plain load sees the other core's store
        issue(1, 1, 0, 0, 32'h100, 0, lat, val, wdn, sw, wa, wd);
        check("lw_data", val, 32'h77);

        // Slow RAM with ramready held high outside accesses
        ram_spur = 1'b1;
        ram_lat  = 2;
        issue(0, 1, 0, 0, 32'h104, 0, lat, val, wdn, sw, wa, wd);
        check("slow_lat", lat, 5);
        check("slow_data", val, 32'h9);
        ram_spur = 1'b0;

        // Reset in the middle of an access
        ram_lat = 0;
        issue(0, 1, 0, 1, 32'h100, 0, lat, val, wdn, sw, wa, wd);
        ram_lat = 5;
        @(negedge CLK);
        dREN[0] = 1'b1; daddr[0] = 32'h100;
        @(negedge CLK);
        check("mid_access_ren", ramREN, 1'b1);
        RST = 1'b1;
        clear_reqs();
        @(negedge CLK);
        check("mid_rst_ren", {ramREN, ramWEN}, 2'b00);
        check("mid_rst_waits", {iwait, dwait}, 4'hF);
        RST = 1'b0;
        ram_lat = 0;
        // Link from before reset is gone
        issue(0, 1, 1, 1, 32'h100, 32'hAA, lat, val, wdn, sw, wa, wd);
        check("post_rst_sc_val", val, 32'd0);
        check("post_rst_sc_lat", lat, 2);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
